receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rx_sync.sv | 21 ++
 rtl/receiver.sv | 154 +++++++++++++++
 tb/tb_receiver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and default oversampling.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] PAR_NONE     = 2'd0;
  localparam logic [1:0] PAR_ODD      = 2'd1;
  localparam logic [1:0] PAR_EVEN     = 2'd2;
  localparam logic [1:0] PAR_NONE_ALT = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } rx_state_t;

  // Parity bit a correct transmitter would send for this word; unused upper bits must be zero.
  function automatic logic parity_expected(input logic [1:0] mode, input logic [7:0] word);
    return (mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input; both flops reset to the idle level.
module rx_sync (
  input  logic clk_rx,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/receiver.sv
// Oversampling UART receiver: 7/8 data bits, optional odd/even parity, 1 or 2 stop bits.
// Define RX_SYNC_EN to pass rx through a two-flop synchronizer (adds 2 cycles of latency).
module receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk_rx,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] par,
  input  logic       d_num,
  input  logic       s_num,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

  logic rx_s;

`ifdef RX_SYNC_EN
  rx_sync u_rx_sync (
    .clk_rx (clk_rx),
    .reset  (reset),
    .rx     (rx),
    .rx_s   (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  rx_state_t        state;
  logic [CNT_W-1:0] tick;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [1:0]       par_l;
  logic             d_num_l;
  logic             s_num_l;
  logic             perr_pend;
  logic             ferr_pend;

  logic [7:0] word;
  logic       has_par;
  logic       tick_done;

  // In 7-bit mode only seven shifts happen, so the word sits in the top seven bits.
  assign word      = d_num_l ? shift : {1'b0, shift[7:1]};
  assign has_par   = (par_l == PAR_ODD) || (par_l == PAR_EVEN);
  assign tick_done = (tick == FULL_LAST);

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_l      <= PAR_NONE;
      d_num_l    <= 1'b0;
      s_num_l    <= 1'b0;
      perr_pend  <= 1'b0;
      ferr_pend  <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      tick  <= tick + 1'b1;
      case (state)
        IDLE: begin
          tick <= '0;
          if (!rx_s) begin
            state     <= START;
            busy      <= 1'b1;
            par_l     <= par;
            d_num_l   <= d_num;
            s_num_l   <= s_num;
            bit_idx   <= '0;
            perr_pend <= 1'b0;
            ferr_pend <= 1'b0;
          end
        end
        START: begin
          if (tick == HALF_LAST) begin
            tick <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick_done) begin
            tick    <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == {2'b11, d_num_l})
              state <= has_par ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (tick_done) begin
            tick <= '0;
            if (rx_s != parity_expected(par_l, word))
              perr_pend <= 1'b1;
            state <= STOP1;
          end
        end
        STOP1: begin
          if (tick_done) begin
            tick <= '0;
            if (s_num_l) begin
              if (!rx_s)
                ferr_pend <= 1'b1;
              state <= STOP2;
            end else begin
              valid      <= 1'b1;
              data_out   <= word;
              parity_err <= perr_pend;
              frame_err  <= ferr_pend | ~rx_s;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        STOP2: begin
          if (tick_done) begin
            tick       <= '0;
            valid      <= 1'b1;
            data_out   <= word;
            parity_err <= perr_pend;
            frame_err  <= ferr_pend | ~rx_s;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: table-driven frames, hand-written corner cases, random loopback.
module tb_receiver;

  localparam int OS = 16;
`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk_rx = 1'b0;
  logic       reset;
  logic       rx;
  logic [1:0] par;
  logic       d_num;
  logic       s_num;
  logic [7:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  receiver #(.OVERSAMPLE(OS)) dut (
    .clk_rx     (clk_rx),
    .reset      (reset),
    .rx         (rx),
    .par        (par),
    .d_num      (d_num),
    .s_num      (s_num),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk_rx = ~clk_rx;
  always @(posedge clk_rx) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] par;
    logic       d_num;
    logic       s_num;
    logic [7:0] data;
    logic       pbit;
    logic       stop1;
    logic       stop2;
  } frame_t;

  typedef struct {
    frame_t     f;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  logic prev_v = 1'b0;
  int   dbl = 0;

  // Monitor: every valid pulse is logged with the cycle it was seen in.
  always @(negedge clk_rx) begin
    if (valid) got_q.push_back('{cyc, data_out, parity_err, frame_err});
    if (valid && prev_v) dbl++;
    prev_v = valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_rx);
      #1;
    end
  endtask

  // Reference model: what a correct receiver reports for a frame, from the frame rules alone.
  function automatic void model(input frame_t f, output logic [7:0] d, output logic pe,
                                output logic fe);
    int nd;
    int ones;
    nd   = f.d_num ? 8 : 7;
    ones = 0;
    d    = 8'h00;
    for (int i = 0; i < nd; i++) begin
      d[i] = f.data[i];
      ones += int'(f.data[i]);
    end
    pe = 1'b0;
    if (f.par == 2'd1) pe = ((ones + int'(f.pbit)) % 2) == 0;
    if (f.par == 2'd2) pe = ((ones + int'(f.pbit)) % 2) == 1;
    fe = !f.stop1 || (f.s_num && !f.stop2);
  endfunction

  // Drives one complete frame from posedge+1 alignment; returns the cycle valid should be seen.
  task automatic send_frame(input frame_t f, input bit scramble, output int exp_c);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < (f.d_num ? 8 : 7); i++) b.push_back(f.data[i]);
    if (f.par == 2'd1 || f.par == 2'd2) b.push_back(f.pbit);
    b.push_back(f.stop1);
    if (f.s_num) b.push_back(f.stop2);
    par   = f.par;
    d_num = f.d_num;
    s_num = f.s_num;
    exp_c = cyc + 1 + OS / 2 + OS * (b.size() - 1) + LAT;
    foreach (b[k]) begin
      rx = b[k];
      if (scramble && k == 1) begin
        par   = 2'($urandom_range(3));
        d_num = 1'($urandom_range(1));
        s_num = 1'($urandom_range(1));
      end
      step(OS);
    end
    rx = 1'b1;
  endtask

  task automatic expect_rec(input string tag, input int exp_c, input logic [7:0] d,
                            input logic pe, input logic fe);
    rec_t r;
    int   waited;
    waited = 0;
    while (got_q.size() == 0 && waited < 64) begin
      step(1);
      waited++;
    end
    if (got_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s valid: no valid pulse within 64 cycles", tag);
      return;
    end
    r = got_q.pop_front();
    chk({tag, " cycle"}, r.c, exp_c);
    chk({tag, " data"}, r.d, d);
    chk({tag, " parity_err"}, r.pe, pe);
    chk({tag, " frame_err"}, r.fe, fe);
  endtask

  vec_t vecs[8];

  initial begin
    int     ec;
    int     nq;
    int     bcnt;
    logic [7:0] d0;
    frame_t f;
    logic [7:0] md;
    logic   mpe;
    logic   mfe;
    rec_t   g;
    rec_t   e;

    vecs[0] = '{'{2'd0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1}, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{'{2'd1, 1'b0, 1'b0, 8'h35, 1'b1, 1'b1, 1'b1}, 8'h35, 1'b0, 1'b0};
    vecs[2] = '{'{2'd1, 1'b0, 1'b0, 8'h35, 1'b0, 1'b1, 1'b1}, 8'h35, 1'b1, 1'b0};
    vecs[3] = '{'{2'd2, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0}, 8'h0F, 1'b0, 1'b1};
    vecs[4] = '{'{2'd3, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1}, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{'{2'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1}, 8'h7F, 1'b0, 1'b0};
    vecs[6] = '{'{2'd2, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1}, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{'{2'd1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1}, 8'h00, 1'b0, 1'b0};

    reset = 1'b1;
    rx    = 1'b1;
    par   = 2'd0;
    d_num = 1'b1;
    s_num = 1'b0;
    step(4);
    reset = 1'b0;
    chk("reset data_out", data_out, 8'h00);
    chk("reset valid", valid, 1'b0);
    chk("reset parity_err", parity_err, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset busy", busy, 1'b0);
    step(5);

    foreach (vecs[i]) begin
      send_frame(vecs[i].f, 1'b0, ec);
      expect_rec($sformatf("vec%0d", i), ec, vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
      step(4);
      chk($sformatf("vec%0d busy after", i), busy, 1'b0);
      chk($sformatf("vec%0d data hold", i), data_out, vecs[i].exp_d);
    end

    // Glitch: 3 low cycles look like a start, get rejected at mid-bit.
    nq   = got_q.size();
    d0   = data_out;
    bcnt = 0;
    for (int i = 0; i < 24; i++) begin
      rx = (i < 3) ? 1'b0 : 1'b1;
      step(1);
      if (busy) bcnt++;
    end
    chk("glitch busy cycles", bcnt, 8);
    chk("glitch no valid", got_q.size(), nq);
    chk("glitch data_out kept", data_out, d0);
    chk("glitch busy low", busy, 1'b0);

    // Reset in the middle of data bit 4 of 0x3C, then a clean 0xC3 frame.
    par   = 2'd0;
    d_num = 1'b1;
    s_num = 1'b0;
    d0    = 8'h3C;
    rx    = 1'b0;
    step(OS);
    for (int i = 0; i < 4; i++) begin
      rx = d0[i];
      step(OS);
    end
    rx = d0[4];
    step(OS / 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rx    = 1'b1;
    chk("abort busy", busy, 1'b0);
    chk("abort data_out", data_out, 8'h00);
    step(3 * OS);
    chk("abort no valid", got_q.size(), nq);
    f = '{2'd0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1};
    send_frame(f, 1'b0, ec);
    expect_rec("after abort", ec, 8'hC3, 1'b0, 1'b0);
    chk("after abort single", got_q.size(), 0);
    step(10);

    // Random loopback: every mode combination, back-to-back frames, config toggled mid-frame.
    for (int m = 0; m < 16; m++) begin
      for (int k = 0; k < 3; k++) begin
        f.par   = 2'(m & 3);
        f.d_num = 1'((m >> 2) & 1);
        f.s_num = 1'((m >> 3) & 1);
        f.data  = 8'($urandom_range(255));
        f.pbit  = 1'($urandom_range(1));
        f.stop1 = 1'b1;
        f.stop2 = 1'b1;
        model(f, md, mpe, mfe);
        if (mpe && $urandom_range(3) != 0) begin
          f.pbit = ~f.pbit;
          model(f, md, mpe, mfe);
        end
        send_frame(f, 1'b1, ec);
        exp_q.push_back('{ec, md, mpe, mfe});
      end
    end
    step(8);
    chk("loopback frame count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk("loop cycle", g.c, e.c);
      chk("loop data", g.d, e.d);
      chk("loop parity_err", g.pe, e.pe);
      chk("loop frame_err", g.fe, e.fe);
    end
    chk("valid single cycle", dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
